seq_det_scheduler: RTL and testbench
====================================

Name: seq_det_scheduler

Overview:
- Round-robin controller that shares one external Moore sequence detector (1-bit input `x`, 2-bit output `y`, synchronous active-high reset) among N_REQ requesters.
- For each granted request it clears the detector, shifts the request's bit-string in MSB-first and samples every Moore output. It counts `y==2'b01` and `y==2'b11` hits and returns the counts over a valid/ready response.
- Sits between the requester blocks and the detector instance.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- W, 16, maximum bit-string length per request.
- LW, $clog2(W+1), width of the length and count fields.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- req  in  N_REQ  per-requester request, level; held until the matching grant pulse.
- req_data  in  N_REQ*W  flattened bit-strings; slot i is [i*W +: W]; LSB-aligned.
- req_len  in  N_REQ*LW  flattened lengths; slot i is [i*LW +: LW]; values above W are clamped to W.
- grant  out  N_REQ  one-hot, one-cycle pulse when a request is accepted.
- det_x  out  1  drives detector `x`.
- det_rst  out  1  drives detector reset (active-high, synchronous).
- det_y  in  2  detector Moore output.
- rsp_valid  out  1  response valid.
- rsp_ready  in  1  response accept.
- rsp_id  out  $clog2(N_REQ)  requester index for the response.
- rsp_cnt01  out  LW  count of cycles with det_y==01.
- rsp_cnt11  out  LW  count of cycles with det_y==11.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset (rst low, async): state=IDLE, rr_ptr=0, grant=0, det_x=0, det_rst=1, rsp_valid=0, rsp_id=0, both counts=0, busy=0.
  - det_rst stays 1 until the first clk edge after reset release, then goes to 0.
- States: IDLE, CLEAR, SHIFT, DRAIN, RESP.
- IDLE:
  - If req is nonzero, select the first set bit scanning from rr_ptr upward with wrap-around.
  - Pulse grant[sel] this cycle; latch data, clamped length and id; zero the counters.
  - If the latched length is 0, go to RESP. Otherwise go to CLEAR.
- CLEAR: det_rst=1, det_x=0 for exactly one cycle; idx=0; go to SHIFT.
- SHIFT:
  - det_x = data[len-1-idx]; idx increments each cycle.
  - From the second SHIFT cycle onward, sample det_y, which reflects the bit driven in the previous cycle.
  - After idx reaches len-1, go to DRAIN.
- DRAIN: det_x=0; sample det_y once (last bit); go to RESP.
- Sampling: det_y==01 increments cnt01; det_y==11 increments cnt11; 00 and 10 are ignored. Counters saturate at 2^LW-1.
- RESP:
  - rsp_valid=1; rsp_* stable until the handshake.
  - On rsp_valid&&rsp_ready: rr_ptr=(id+1) mod N_REQ, go to IDLE.
  - No new grant is issued until the following cycle.
- Latency: for len L≥1, rsp_valid rises L+3 cycles after the grant cycle.
- Simultaneous events:
  - Requests arriving outside IDLE wait.
  - A requester deasserting req before grant is simply not served.
  - req sampled in IDLE wins over nothing else; there is no preemption.
- Reset mid-operation: abort immediately; the in-flight request is lost with no response; det_rst=1 per the reset rule.

Optional Feature:
- Macro SCHED_EARLY_STOP_EN.
- With it defined:
  - The first sampled det_y==11 ends SHIFT/DRAIN and the block goes to RESP; the remaining bits are not driven.
  - Extra outputs: rsp_stopped (1 bit) and rsp_consumed (LW bits, the number of bits whose y was sampled).
- Without it: all L bits are always shifted; the extra ports do not exist.

Decomposition:
- Shared package seq_det_pkg:
  - state enum, with IDLE=0.
  - Y_NONE=2'b00, Y_HIT01=2'b01, Y_HIT11=2'b11.
  - default N_REQ and W.
- One sub-module, rr_arbiter: combinational priority pick from req and rr_ptr, giving a one-hot select and its index. The FSM, shifter and counters stay in the top module.

Test Plan:
- Req0, data=5'b10001, len=5 → grant=0001 one cycle; rsp_id=0, cnt01=1, cnt11=0; rsp_valid 8 cycles after grant.
- Req1, data=7'b1010101, len=7 → cnt11=2, cnt01=0, rsp_id=1; det_rst high exactly one cycle before the first bit.
- req=4'b1111 held across four transactions with rsp_ready=1 → grant order 0,1,2,3, then 0 again.
- len=0 on req2 → no det_rst pulse, rsp_valid the cycle after grant, both counts 0; len=20 with W=16 → 16 bits shifted.
- rsp_ready held 0 for 5 cycles in RESP → rsp_* stable, no grant issued; grant resumes the cycle after the handshake.
- rst low during SHIFT → same-cycle return to reset values with det_rst=1; no rsp_valid; with SCHED_EARLY_STOP_EN, data=7'b1010101 gives rsp_stopped=1, rsp_consumed=5, cnt11=1.

Source files
------------

// File: rtl/seq_det_pkg.sv
// Shared types and constants for the sequence-detector scheduler: FSM state
// encoding, detector output codes and default sizing.
package seq_det_pkg;

  localparam int N_REQ_DEF = 4;
  localparam int W_DEF     = 16;

  localparam logic [1:0] Y_NONE  = 2'b00;
  localparam logic [1:0] Y_HIT01 = 2'b01;
  localparam logic [1:0] Y_HIT11 = 2'b11;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CLEAR = 3'd1,
    SHIFT = 3'd2,
    DRAIN = 3'd3,
    RESP  = 3'd4
  } state_t;

endpackage

// File: rtl/seq_det_scheduler_rr_arbiter.sv
// Combinational round-robin pick: first set request at or after ptr, with
// wrap-around, returned both one-hot and as an index.
module rr_arbiter #(
  parameter int N_REQ = 4,
  parameter int IW    = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IW-1:0]    ptr,
  output logic [N_REQ-1:0] sel,
  output logic [IW-1:0]    sel_idx,
  output logic             any
);

  logic [IW-1:0] j;

  // NOTE: every output of a combinational block gets a default before any
  // conditional assignment; a path that skips an assignment infers a latch.
  always_comb begin
    sel     = '0;
    sel_idx = '0;
    any     = 1'b0;
    j       = ptr;
    for (int i = 0; i < N_REQ; i++) begin
      if (!any && req[j]) begin
        any     = 1'b1;
        sel_idx = j;
        sel[j]  = 1'b1;
      end
      j = (j == IW'(N_REQ - 1)) ? '0 : j + 1'b1;
    end
  end

endmodule

// File: rtl/seq_det_scheduler.sv
// Round-robin scheduler sharing one external Moore sequence detector among
// N_REQ requesters. Define SCHED_EARLY_STOP_EN to end a run on the first 11 hit.
module seq_det_scheduler
  import seq_det_pkg::*;
#(
  parameter int N_REQ = N_REQ_DEF,
  parameter int W     = W_DEF,
  parameter int LW    = $clog2(W + 1),
  localparam int IW   = $clog2(N_REQ)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [N_REQ-1:0]  req,
  input  logic [N_REQ*W-1:0]  req_data,
  input  logic [N_REQ*LW-1:0] req_len,
  output logic [N_REQ-1:0]  grant,
  output logic              det_x,
  output logic              det_rst,
  input  logic [1:0]        det_y,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [IW-1:0]     rsp_id,
  output logic [LW-1:0]     rsp_cnt01,
  output logic [LW-1:0]     rsp_cnt11,
`ifdef SCHED_EARLY_STOP_EN
  output logic              rsp_stopped,
  output logic [LW-1:0]     rsp_consumed,
`endif
  output logic              busy
);

  localparam logic [LW-1:0] CNT_MAX = '1;
  localparam logic [LW-1:0] LEN_MAX = LW'(W);

  state_t          state, state_nx;
  logic [IW-1:0]   rr_ptr, id;
  logic [W-1:0]    data, slot_data, data_sh;
  logic [LW-1:0]   len, idx, cnt01, cnt11, slot_len, slot_len_c;
  logic            rst_hold, accept, sample;
  logic [N_REQ-1:0] sel;
  logic [IW-1:0]   sel_idx;
  logic            sel_any;
`ifdef SCHED_EARLY_STOP_EN
  logic            stopped;
  logic [LW-1:0]   consumed;
`endif

  rr_arbiter #(.N_REQ(N_REQ), .IW(IW)) u_arb (
    .req     (req),
    .ptr     (rr_ptr),
    .sel     (sel),
    .sel_idx (sel_idx),
    .any     (sel_any)
  );

  assign slot_data  = req_data[sel_idx*W +: W];
  assign slot_len   = req_len[sel_idx*LW +: LW];
  assign slot_len_c = (slot_len > LEN_MAX) ? LEN_MAX : slot_len;
  // MSB-first: bit len-1-idx of the latched string lands in data_sh[0].
  assign data_sh    = data >> (len - idx - 1'b1);
  // No accept while the detector is still held in its post-reset clear.
  assign accept     = (state == IDLE) && !rst_hold && sel_any;
  // det_y lags det_x by one cycle, so the first SHIFT cycle has nothing to see.
  assign sample     = ((state == SHIFT) && (idx != '0)) || (state == DRAIN);

  always_comb begin
    state_nx  = state;
    grant     = '0;
    det_x     = 1'b0;
    det_rst   = rst_hold;
    rsp_valid = 1'b0;
    case (state)
      IDLE: if (accept) begin
        grant    = sel;
        state_nx = (slot_len_c == '0) ? RESP : CLEAR;
      end
      CLEAR: begin
        det_rst  = 1'b1;
        state_nx = SHIFT;
      end
      SHIFT: begin
        det_x = data_sh[0];
        if (idx == len - 1'b1) state_nx = DRAIN;
      end
      DRAIN: state_nx = RESP;
      RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
`ifdef SCHED_EARLY_STOP_EN
    if (sample && (det_y == Y_HIT11)) begin
      det_x    = 1'b0;
      state_nx = RESP;
    end
`endif
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      rr_ptr   <= '0;
      id       <= '0;
      idx      <= '0;
      cnt01    <= '0;
      cnt11    <= '0;
      rst_hold <= 1'b1;
`ifdef SCHED_EARLY_STOP_EN
      stopped  <= 1'b0;
      consumed <= '0;
`endif
    end else begin
      state    <= state_nx;
      rst_hold <= 1'b0;
      if (accept) begin
        id    <= sel_idx;
        cnt01 <= '0;
        cnt11 <= '0;
`ifdef SCHED_EARLY_STOP_EN
        stopped  <= 1'b0;
        consumed <= '0;
`endif
      end
      if (state == CLEAR)      idx <= '0;
      else if (state == SHIFT) idx <= idx + 1'b1;
      if (sample) begin
        if ((det_y == Y_HIT01) && (cnt01 != CNT_MAX)) cnt01 <= cnt01 + 1'b1;
        if ((det_y == Y_HIT11) && (cnt11 != CNT_MAX)) cnt11 <= cnt11 + 1'b1;
`ifdef SCHED_EARLY_STOP_EN
        consumed <= consumed + 1'b1;
        if (det_y == Y_HIT11) stopped <= 1'b1;
`endif
      end
      if (rsp_valid && rsp_ready)
        rr_ptr <= (id == IW'(N_REQ - 1)) ? '0 : id + 1'b1;
    end
  end

  // NOTE: the payload registers carry no reset; they are always reloaded on
  // accept before anything reads them.
  always_ff @(posedge clk) begin
    if (accept) begin
      data <= slot_data;
      len  <= slot_len_c;
    end
  end

  assign rsp_id    = id;
  assign rsp_cnt01 = cnt01;
  assign rsp_cnt11 = cnt11;
  assign busy      = (state != IDLE);
`ifdef SCHED_EARLY_STOP_EN
  assign rsp_stopped  = stopped;
  assign rsp_consumed = consumed;
`endif

endmodule

// File: tb/tb_seq_det_scheduler.sv
// Directed bench for seq_det_scheduler with a behavioural Moore detector:
// y=11 after "10101" (overlapping), y=01 after "001", else 00.
module tb_seq_det_scheduler;

  localparam int N_REQ = 4;
  localparam int W     = 16;
  localparam int LW    = 5;
  localparam int IW    = 2;

  logic                  clk = 1'b0;
  logic                  rst = 1'b0;
  logic [N_REQ-1:0]      req = '0;
  logic [N_REQ*W-1:0]    req_data = '0;
  logic [N_REQ*LW-1:0]   req_len = '0;
  logic [N_REQ-1:0]      grant;
  logic                  det_x, det_rst;
  logic [1:0]            det_y;
  logic                  rsp_valid;
  logic                  rsp_ready = 1'b1;
  logic [IW-1:0]         rsp_id;
  logic [LW-1:0]         rsp_cnt01, rsp_cnt11;
  logic                  busy;
`ifdef SCHED_EARLY_STOP_EN
  logic                  rsp_stopped;
  logic [LW-1:0]         rsp_consumed;
`endif

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  seq_det_scheduler #(.N_REQ(N_REQ), .W(W), .LW(LW)) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .req_data  (req_data),
    .req_len   (req_len),
    .grant     (grant),
    .det_x     (det_x),
    .det_rst   (det_rst),
    .det_y     (det_y),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_cnt01 (rsp_cnt01),
    .rsp_cnt11 (rsp_cnt11),
`ifdef SCHED_EARLY_STOP_EN
    .rsp_stopped  (rsp_stopped),
    .rsp_consumed (rsp_consumed),
`endif
    .busy      (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Detector model: synchronous active-high reset, Moore output from history.
  logic [4:0] hist = '0;
  int         nb   = 0;
  always @(posedge clk) begin
    if (det_rst) begin
      hist <= '0;
      nb   <= 0;
    end else begin
      hist <= {hist[3:0], det_x};
      if (nb < 5) nb <= nb + 1;
    end
  end
  always_comb begin
    if (nb >= 5 && hist == 5'b10101)          det_y = 2'b11;
    else if (nb >= 3 && hist[2:0] == 3'b001)  det_y = 2'b01;
    else                                      det_y = 2'b00;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic do_reset();
    req = '0;
    rsp_ready = 1'b1;
    rst = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic wait_grant(input int budget, output int t);
    t = -1;
    for (int k = 0; k < budget; k++) begin
      if (grant != '0) begin
        t = cyc;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic wait_valid(input int budget, output int t, output int rc, output int rn);
    t = -1; rc = -1; rn = 0;
    for (int k = 0; k < budget; k++) begin
      if (rsp_valid) begin
        t = cyc;
        break;
      end
      if (det_rst) begin
        rn++;
        if (rc < 0) rc = cyc;
      end
      @(negedge clk);
    end
  endtask

  // Raise one request, wait for its grant and then its response; returns at
  // the first rsp_valid cycle (sampled mid-cycle).
  task automatic txn(input int i, input logic [W-1:0] d, input logic [LW-1:0] l,
                     input bit drop, output logic [N_REQ-1:0] g,
                     output logic [N_REQ-1:0] g_next, output int lat,
                     output int rc_off, output int rn);
    int tg, tv, rc;
    req_data[i*W +: W]   = d;
    req_len[i*LW +: LW]  = l;
    req[i]               = 1'b1;
    #1;
    wait_grant(20, tg);
    g = grant;
    @(negedge clk);
    g_next = grant;
    if (drop) req[i] = 1'b0;
    wait_valid(40, tv, rc, rn);
    lat    = (tv < 0 || tg < 0) ? -1 : tv - tg;
    rc_off = (rc < 0 || tg < 0) ? -1 : rc - tg;
  endtask

  task automatic test_reset();
    rst = 1'b0; req = '1; rsp_ready = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    n_cmp++; if (grant !== 4'b0000) begin n_bad++; $display("FAIL reset_grant: got %b want 0000", grant); end
    n_cmp++; if (det_rst !== 1'b1) begin n_bad++; $display("FAIL reset_det_rst: got %b want 1", det_rst); end
    n_cmp++; if (rsp_valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid: got %b want 0", rsp_valid); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_cmp++; if (det_x !== 1'b0) begin n_bad++; $display("FAIL reset_det_x: got %b want 0", det_x); end
    n_cmp++; if (rsp_id !== 2'd0) begin n_bad++; $display("FAIL reset_id: got %0d want 0", rsp_id); end
    n_cmp++; if (rsp_cnt01 !== 5'd0 || rsp_cnt11 !== 5'd0) begin n_bad++; $display("FAIL reset_cnt: got %0d/%0d want 0/0", rsp_cnt01, rsp_cnt11); end
    req = '0;
    #1;
    rst = 1'b1;
    #1;
    n_cmp++; if (det_rst !== 1'b1) begin n_bad++; $display("FAIL reset_release_det_rst: got %b want 1", det_rst); end
    @(negedge clk);
    n_cmp++; if (det_rst !== 1'b0) begin n_bad++; $display("FAIL reset_after_edge_det_rst: got %b want 0", det_rst); end
  endtask

  task automatic test_basic();
    logic [N_REQ-1:0] g, gn; int lat, rc, rn;
    do_reset();
    txn(0, 16'b10001, 5'd5, 1'b1, g, gn, lat, rc, rn);
    n_cmp++; if (g !== 4'b0001) begin n_bad++; $display("FAIL basic_grant: got %b want 0001", g); end
    n_cmp++; if (gn !== 4'b0000) begin n_bad++; $display("FAIL basic_grant_pulse: got %b want 0000", gn); end
    n_cmp++; if (lat !== 8) begin n_bad++; $display("FAIL basic_latency: got %0d want 8", lat); end
    n_cmp++; if (rsp_id !== 2'd0) begin n_bad++; $display("FAIL basic_id: got %0d want 0", rsp_id); end
    n_cmp++; if (rsp_cnt01 !== 5'd1) begin n_bad++; $display("FAIL basic_cnt01: got %0d want 1", rsp_cnt01); end
    n_cmp++; if (rsp_cnt11 !== 5'd0) begin n_bad++; $display("FAIL basic_cnt11: got %0d want 0", rsp_cnt11); end
  endtask

  task automatic test_req1();
    logic [N_REQ-1:0] g, gn; int lat, rc, rn;
    logic [LW-1:0] want11;
`ifdef SCHED_EARLY_STOP_EN
    want11 = 5'd1;
`else
    want11 = 5'd2;
`endif
    do_reset();
    txn(1, 16'b1010101, 5'd7, 1'b1, g, gn, lat, rc, rn);
    n_cmp++; if (g !== 4'b0010) begin n_bad++; $display("FAIL req1_grant: got %b want 0010", g); end
    n_cmp++; if (rsp_id !== 2'd1) begin n_bad++; $display("FAIL req1_id: got %0d want 1", rsp_id); end
    n_cmp++; if (rsp_cnt11 !== want11) begin n_bad++; $display("FAIL req1_cnt11: got %0d want %0d", rsp_cnt11, want11); end
    n_cmp++; if (rsp_cnt01 !== 5'd0) begin n_bad++; $display("FAIL req1_cnt01: got %0d want 0", rsp_cnt01); end
    n_cmp++; if (rn !== 1) begin n_bad++; $display("FAIL req1_det_rst_len: got %0d want 1", rn); end
    n_cmp++; if (rc !== 1) begin n_bad++; $display("FAIL req1_det_rst_pos: got %0d want 1", rc); end
  endtask

  task automatic test_round_robin();
    logic [N_REQ-1:0] g, gn; int lat, rc, rn;
    int order [5] = '{0, 1, 2, 3, 0};
    do_reset();
    for (int s = 0; s < N_REQ; s++) begin
      req_data[s*W +: W]  = '0;
      req_len[s*LW +: LW] = 5'd1;
    end
    req = '1;
    for (int n = 0; n < 5; n++) begin
      txn(order[n], 16'h0000, 5'd1, 1'b0, g, gn, lat, rc, rn);
      n_cmp++; if (g !== 4'(1 << order[n])) begin n_bad++; $display("FAIL rr_grant_%0d: got %b want %b", n, g, 4'(1 << order[n])); end
      n_cmp++; if (rsp_id !== 2'(order[n])) begin n_bad++; $display("FAIL rr_id_%0d: got %0d want %0d", n, rsp_id, order[n]); end
    end
    n_cmp++; if (lat !== 4) begin n_bad++; $display("FAIL rr_latency_len1: got %0d want 4", lat); end
    req = '0;
    @(negedge clk);
  endtask

  task automatic test_len_zero();
    logic [N_REQ-1:0] g, gn; int lat, rc, rn;
    do_reset();
    txn(2, 16'h0015, 5'd0, 1'b1, g, gn, lat, rc, rn);
    n_cmp++; if (g !== 4'b0100) begin n_bad++; $display("FAIL len0_grant: got %b want 0100", g); end
    n_cmp++; if (lat !== 1) begin n_bad++; $display("FAIL len0_latency: got %0d want 1", lat); end
    n_cmp++; if (rn !== 0) begin n_bad++; $display("FAIL len0_det_rst: got %0d pulses want 0", rn); end
    n_cmp++; if (rsp_cnt01 !== 5'd0 || rsp_cnt11 !== 5'd0) begin n_bad++; $display("FAIL len0_cnt: got %0d/%0d want 0/0", rsp_cnt01, rsp_cnt11); end
    n_cmp++; if (rsp_id !== 2'd2) begin n_bad++; $display("FAIL len0_id: got %0d want 2", rsp_id); end
  endtask

  task automatic test_clamp();
    logic [N_REQ-1:0] g, gn; int lat, rc, rn;
    do_reset();
    txn(3, 16'h8888, 5'd20, 1'b1, g, gn, lat, rc, rn);
    n_cmp++; if (lat !== 19) begin n_bad++; $display("FAIL clamp_latency: got %0d want 19", lat); end
    n_cmp++; if (rsp_cnt01 !== 5'd3) begin n_bad++; $display("FAIL clamp_cnt01: got %0d want 3", rsp_cnt01); end
    n_cmp++; if (rsp_cnt11 !== 5'd0) begin n_bad++; $display("FAIL clamp_cnt11: got %0d want 0", rsp_cnt11); end
    n_cmp++; if (rsp_id !== 2'd3) begin n_bad++; $display("FAIL clamp_id: got %0d want 3", rsp_id); end
`ifdef SCHED_EARLY_STOP_EN
    n_cmp++; if (rsp_consumed !== 5'd16) begin n_bad++; $display("FAIL clamp_consumed: got %0d want 16", rsp_consumed); end
    n_cmp++; if (rsp_stopped !== 1'b0) begin n_bad++; $display("FAIL clamp_stopped: got %b want 0", rsp_stopped); end
`endif
  endtask

  task automatic test_back_to_back();
    logic [N_REQ-1:0] g, gn; int lat, rc, rn;
    do_reset();
    rsp_ready = 1'b0;
    req_data[1*W +: W]  = '0;
    req_len[1*LW +: LW] = 5'd1;
    req[1] = 1'b1;
    txn(0, 16'b10001, 5'd5, 1'b1, g, gn, lat, rc, rn);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      n_cmp++; if (rsp_valid !== 1'b1) begin n_bad++; $display("FAIL bp_valid_%0d: got %b want 1", k, rsp_valid); end
      n_cmp++; if (rsp_id !== 2'd0) begin n_bad++; $display("FAIL bp_id_%0d: got %0d want 0", k, rsp_id); end
      n_cmp++; if (rsp_cnt01 !== 5'd1 || rsp_cnt11 !== 5'd0) begin n_bad++; $display("FAIL bp_cnt_%0d: got %0d/%0d want 1/0", k, rsp_cnt01, rsp_cnt11); end
      n_cmp++; if (grant !== 4'b0000) begin n_bad++; $display("FAIL bp_grant_%0d: got %b want 0000", k, grant); end
    end
    rsp_ready = 1'b1;
    #1;
    n_cmp++; if (grant !== 4'b0000) begin n_bad++; $display("FAIL bp_handshake_grant: got %b want 0000", grant); end
    @(negedge clk);
    n_cmp++; if (grant !== 4'b0010) begin n_bad++; $display("FAIL bp_resume_grant: got %b want 0010", grant); end
    n_cmp++; if (rsp_valid !== 1'b0) begin n_bad++; $display("FAIL bp_resume_valid: got %b want 0", rsp_valid); end
    req = '0;
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    int tg; bit seen;
    do_reset();
    req_data[0*W +: W]  = 16'b1010101;
    req_len[0*LW +: LW] = 5'd7;
    req[0] = 1'b1;
    #1;
    wait_grant(20, tg);
    @(negedge clk);
    req = '0;
    repeat (2) @(negedge clk);
    n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL mid_busy_before: got %b want 1", busy); end
    rst = 1'b0;
    #1;
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL mid_busy: got %b want 0", busy); end
    n_cmp++; if (det_rst !== 1'b1) begin n_bad++; $display("FAIL mid_det_rst: got %b want 1", det_rst); end
    n_cmp++; if (rsp_valid !== 1'b0) begin n_bad++; $display("FAIL mid_valid: got %b want 0", rsp_valid); end
    n_cmp++; if (det_x !== 1'b0) begin n_bad++; $display("FAIL mid_det_x: got %b want 0", det_x); end
    @(negedge clk);
    rst = 1'b1;
    seen = 1'b0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (rsp_valid) seen = 1'b1;
    end
    n_cmp++; if (seen !== 1'b0) begin n_bad++; $display("FAIL mid_no_response: got %b want 0", seen); end
  endtask

`ifdef SCHED_EARLY_STOP_EN
  task automatic test_early_stop();
    logic [N_REQ-1:0] g, gn; int lat, rc, rn;
    do_reset();
    txn(1, 16'b1010101, 5'd7, 1'b1, g, gn, lat, rc, rn);
    n_cmp++; if (rsp_stopped !== 1'b1) begin n_bad++; $display("FAIL es_stopped: got %b want 1", rsp_stopped); end
    n_cmp++; if (rsp_consumed !== 5'd5) begin n_bad++; $display("FAIL es_consumed: got %0d want 5", rsp_consumed); end
    n_cmp++; if (rsp_cnt11 !== 5'd1) begin n_bad++; $display("FAIL es_cnt11: got %0d want 1", rsp_cnt11); end
    n_cmp++; if (lat !== 8) begin n_bad++; $display("FAIL es_latency: got %0d want 8", lat); end
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_req1();
    test_round_robin();
    test_len_zero();
    test_clamp();
    test_back_to_back();
    test_reset_mid();
`ifdef SCHED_EARLY_STOP_EN
    test_early_stop();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
